dipsw_debounce: RTL

DIPSW_DEBOUNCE -- requirements
Module: dipsw_debounce

---
 rtl/dipsw_pkg.sv | 16 +
 rtl/dipsw_debounce_bit.sv | 90 +++++++++
 rtl/dipsw_debounce.sv | 29 ++
 3 files changed

// File: rtl/dipsw_pkg.sv
// Shared types and helpers for the DIP-switch debouncer.
package dipsw_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } dbnc_state_e;

    // Bits needed to hold counts 0..cycles inclusive.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/dipsw_debounce_bit.sv
// One switch bit: two-flop synchronizer, STABLE/SETTLE FSM and saturating counter.
module dipsw_debounce_bit
    import dipsw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic out_bit,
    output logic change_pulse,
    output logic settling
);

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    dbnc_state_e      state;
    dbnc_state_e      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             out_nxt;
    logic             pulse_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= RESET_VALUE;
            sync2        <= RESET_VALUE;
            state        <= STABLE;
            cnt          <= '0;
            out_bit      <= RESET_VALUE;
            change_pulse <= 1'b0;
            settling     <= 1'b0;
        end else begin
            sync1        <= raw_in;
            sync2        <= sync1;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            out_bit      <= out_nxt;
            change_pulse <= pulse_nxt;
            settling     <= (state_nxt == SETTLE);
        end
    end

    // Accept happens on the edge the count reaches DEBOUNCE_CYCLES, so SETTLE never lingers at the limit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out_bit;
        pulse_nxt = 1'b0;
        cnt_inc   = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

        case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (sync2 != out_bit) begin
                    if (cnt_inc == CNT_MAX) begin
                        out_nxt   = sync2;
                        pulse_nxt = 1'b1;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
            SETTLE: begin
                if (sync2 == out_bit) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    out_nxt   = sync2;
                    pulse_nxt = 1'b1;
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dipsw_debounce.sv
// Debounces a bank of DIP switches feeding a PIO; every bit is filtered independently.
module dipsw_debounce #(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] change_pulse,
    output logic [WIDTH-1:0] settling
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        dipsw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clk          (clk),
            .reset_n      (reset_n),
            .raw_in       (raw_in[i]),
            .out_bit      (out_port[i]),
            .change_pulse (change_pulse[i]),
            .settling     (settling[i])
        );
    end

endmodule
